// File: rtl/sb_spi_pkg.sv
// Shared definitions for the iCE40 hard-SPI system-bus sequencer.
//   op_e     : command opcodes on the sequencer command port
//   REG_*    : SPI macro register offsets (low address nibble)
//   SR_*_BIT : status register ready-flag bit positions
//   state_e  : sequencer FSM states
package sb_spi_pkg;

  typedef enum logic [1:0] {
    OP_RD   = 2'b00,
    OP_WR   = 2'b01,
    OP_XCHG = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  localparam logic [3:0] REG_SR   = 4'hC;
  localparam logic [3:0] REG_TXDR = 4'hD;
  localparam logic [3:0] REG_RXDR = 4'hE;

  localparam int SR_TRDY_BIT = 4;
  localparam int SR_RRDY_BIT = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REG_ACC,
    ST_POLL_TX,
    ST_WR_TX,
    ST_POLL_RX,
    ST_RD_RX,
    ST_RESP
  } state_e;

endpackage

// File: rtl/sb_bus_access.sv
// Single system-bus strobe/ack transaction with ack timeout.
//   clk_i, rst_ni          : clock, async active-low reset
//   start_i                : launch an access (ignored while a strobe is up)
//   rw_i, addr_i, wdata_i  : access attributes, registered at start
//   done_o                 : one-cycle pulse, access finished (ack or timeout)
//   rdata_o                : read data, valid with done_o (0 on timeout)
//   timeout_o              : qualifies done_o, no ack arrived in time
//   sb_*                   : connection to the SPI macro system bus
module sb_bus_access #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       timeout_o,
  output logic       sb_stb_o,
  output logic       sb_rw_o,
  output logic [7:0] sb_adr_o,
  output logic [7:0] sb_dat_o,
  input  logic [7:0] sb_dat_i,
  input  logic       sb_ack_i
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic             stb_q, stb_d;
  logic             rw_q, rw_d;
  logic [7:0]       adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_hit, to_hit;

  // Ack only counts while our strobe is up; a stray ack with strobe low is dropped.
  assign ack_hit = stb_q & sb_ack_i;
  assign to_hit  = stb_q & ~sb_ack_i & (cnt_q == CNT_LAST);

  always_comb begin
    stb_d = stb_q;
    rw_d  = rw_q;
    adr_d = adr_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (stb_q) begin
      if (ack_hit || to_hit) begin
        stb_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (start_i) begin
      // Attributes are frozen here so they stay stable for the whole strobe.
      stb_d = 1'b1;
      cnt_d = '0;
      rw_d  = rw_i;
      adr_d = addr_i;
      dat_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q <= 1'b0;
      rw_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      stb_q <= stb_d;
      rw_q  <= rw_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o    = ack_hit | to_hit;
  assign timeout_o = to_hit;
  assign rdata_o   = ack_hit ? sb_dat_i : 8'h00;
  assign sb_stb_o  = stb_q;
  assign sb_rw_o   = rw_q;
  assign sb_adr_o  = adr_q;
  assign sb_dat_o  = dat_q;

endmodule

// File: rtl/sb_spi_host_sequencer.sv
// Fabric-side system-bus initiator for the iCE40 hard SPI macro.
//   clk_i, rst_ni                         : clock (also SBCLKI), async active-low reset
//   cmd_valid_i/cmd_ready_o               : command handshake (ready only in IDLE)
//   cmd_op_i, cmd_addr_i, cmd_wdata_i     : opcode, register offset, write/TX byte
//   rsp_valid_o, rsp_data_o, rsp_err_o    : one-cycle completion with data and error
//   sb_stb_o, sb_rw_o, sb_adr_o, sb_dat_o : to SBSTBI, SBRWI, SBADRI, SBDATI
//   sb_dat_i, sb_ack_i                    : from SBDATO, SBACKO
module sb_spi_host_sequencer
  import sb_spi_pkg::*;
#(
  parameter logic [3:0] BUS_ADDR74  = 4'b0000,
  parameter int         ACK_TIMEOUT = 16,
  parameter int         POLL_LIMIT  = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [3:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       sb_stb_o,
  output logic       sb_rw_o,
  output logic [7:0] sb_adr_o,
  output logic [7:0] sb_dat_o,
  input  logic [7:0] sb_dat_i,
  input  logic       sb_ack_i
);

  localparam logic [8:0] POLL_LAST = 9'(POLL_LIMIT - 1);

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       rw_q, rw_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [8:0] poll_cnt_q, poll_cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  logic       acc_start, acc_rw, acc_done, acc_timeout;
  logic [3:0] acc_off;
  logic [7:0] acc_wdata, acc_rdata;
  logic       fin, fin_err;
  logic [7:0] fin_data;
  op_e        op;

  assign op = op_e'(cmd_op_i);

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    poll_cnt_d  = poll_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    acc_start   = 1'b0;
    acc_rw      = 1'b0;
    acc_off     = REG_SR;
    acc_wdata   = wdata_q;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_data    = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          rw_d    = (op == OP_WR);
          // The first access launches straight from the accept cycle so the
          // strobe rises on the very next cycle.
          case (op)
            OP_RD, OP_WR: begin
              acc_start = 1'b1;
              acc_rw    = (op == OP_WR);
              acc_off   = cmd_addr_i;
              acc_wdata = cmd_wdata_i;
              state_d   = ST_REG_ACC;
            end
            OP_XCHG: begin
              acc_start  = 1'b1;
              poll_cnt_d = '0;
              state_d    = ST_POLL_TX;
            end
            default: begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          endcase
        end
      end
      ST_REG_ACC: begin
        acc_rw  = rw_q;
        acc_off = addr_q;
        if (acc_done) begin
          fin      = 1'b1;
          fin_err  = acc_timeout;
          fin_data = rw_q ? 8'h00 : acc_rdata;
        end
      end
      ST_POLL_TX, ST_POLL_RX: begin
        // A new status read starts in the first strobe-low cycle, giving the
        // mandatory idle gap between accesses.
        acc_start = ~sb_stb_o;
        if (acc_done) begin
          if (acc_timeout) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else if ((state_q == ST_POLL_TX) && acc_rdata[SR_TRDY_BIT]) begin
            state_d = ST_WR_TX;
          end else if ((state_q == ST_POLL_RX) && acc_rdata[SR_RRDY_BIT]) begin
            state_d = ST_RD_RX;
          end else if (poll_cnt_q == POLL_LAST) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end
      end
      ST_WR_TX: begin
        acc_start = ~sb_stb_o;
        acc_rw    = 1'b1;
        acc_off   = REG_TXDR;
        if (acc_done) begin
          if (acc_timeout) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else begin
            poll_cnt_d = '0;
            state_d    = ST_POLL_RX;
          end
        end
      end
      ST_RD_RX: begin
        acc_start = ~sb_stb_o;
        acc_off   = REG_RXDR;
        if (acc_done) begin
          fin      = 1'b1;
          fin_err  = acc_timeout;
          fin_data = acc_rdata;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
      rsp_data_d  = fin_err ? 8'h00 : fin_data;
    end
  end

  // Ready is registered, so it first appears one clock after reset release.
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      poll_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      poll_cnt_q  <= poll_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

  sb_bus_access #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_bus (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (acc_start),
    .rw_i     (acc_rw),
    .addr_i   ({BUS_ADDR74, acc_off}),
    .wdata_i  (acc_wdata),
    .done_o   (acc_done),
    .rdata_o  (acc_rdata),
    .timeout_o(acc_timeout),
    .sb_stb_o (sb_stb_o),
    .sb_rw_o  (sb_rw_o),
    .sb_adr_o (sb_adr_o),
    .sb_dat_o (sb_dat_o),
    .sb_dat_i (sb_dat_i),
    .sb_ack_i (sb_ack_i)
  );

endmodule

// File: tb/tb_sb_spi_host_sequencer.sv
// Scoreboard bench for sb_spi_host_sequencer with a behavioural SPI-macro bus slave.
module tb_sb_spi_host_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       sb_stb;
  logic       sb_rw;
  logic [7:0] sb_adr;
  logic [7:0] sb_dat_o;
  logic [7:0] sb_dat_i = 8'h00;
  logic       sb_ack = 1'b0;

  sb_spi_host_sequencer dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_op_i   (cmd_op),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .sb_stb_o   (sb_stb),
    .sb_rw_o    (sb_rw),
    .sb_adr_o   (sb_adr),
    .sb_dat_o   (sb_dat_o),
    .sb_dat_i   (sb_dat_i),
    .sb_ack_i   (sb_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic err; } rsp_t;
  typedef struct packed { logic rw; logic [7:0] adr; logic [7:0] dat; } acc_t;

  rsp_t       exp_q[$];
  acc_t       acc_q[$];
  logic [7:0] sr_q[$];
  logic [7:0] rx_val = 8'h00;
  int         ack_dly = 1;
  bit         ack_en = 1'b1;
  int         last_width = 0;
  int         acc_total = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         rsp_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave: acks ack_dly cycles after strobe rise, logs and checks each access.
  int         hi_cnt = 0;
  logic [7:0] rd_val = 8'h00;
  logic       cap_rw = 1'b0;
  logic [7:0] cap_adr = 8'h00, cap_dat = 8'h00;
  always @(posedge clk) begin
    acc_t e;
    #1;
    if (sb_stb) begin
      hi_cnt++;
      if (hi_cnt == 1) begin
        cap_rw = sb_rw; cap_adr = sb_adr; cap_dat = sb_dat_o;
        acc_total++;
        checks++;
        if (acc_q.size() == 0) begin
          errors++;
          $display("FAIL access_unexpected: got rw=%0b adr=%0h dat=%0h, none expected", sb_rw, sb_adr, sb_dat_o);
        end else begin
          e = acc_q.pop_front();
          if (e.rw !== sb_rw || e.adr !== sb_adr || (e.rw && e.dat !== sb_dat_o)) begin
            errors++;
            $display("FAIL access: got rw=%0b adr=%0h dat=%0h expected rw=%0b adr=%0h dat=%0h",
                     sb_rw, sb_adr, sb_dat_o, e.rw, e.adr, e.dat);
          end
        end
        rd_val = 8'h77;
        if (sb_adr == 8'h0C) rd_val = (sr_q.size() != 0) ? sr_q.pop_front() : 8'h00;
        else if (sb_adr == 8'h0E) rd_val = rx_val;
      end else if (sb_rw !== cap_rw || sb_adr !== cap_adr || sb_dat_o !== cap_dat) begin
        errors++;
        $display("FAIL strobe_stable: got rw=%0b adr=%0h dat=%0h expected rw=%0b adr=%0h dat=%0h",
                 sb_rw, sb_adr, sb_dat_o, cap_rw, cap_adr, cap_dat);
      end
      if (ack_en && hi_cnt == ack_dly + 1) begin
        sb_ack = 1'b1; sb_dat_i = rd_val;
      end else begin
        sb_ack = 1'b0; sb_dat_i = 8'h00;
      end
    end else begin
      if (hi_cnt != 0) last_width = hi_cnt;
      hi_cnt = 0;
      sb_ack = 1'b0;
      sb_dat_i = 8'h00;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n) begin
      if (rsp_valid) begin
        rsp_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got data=%0h err=%0b, none expected", rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (rsp_data !== e.data || rsp_err !== e.err) begin
            errors++;
            $display("FAIL rsp: got data=%0h err=%0b expected data=%0h err=%0b", rsp_data, rsp_err, e.data, e.err);
          end
        end
        if (prev_valid) begin
          errors++;
          $display("FAIL rsp_pulse: got valid for 2+ cycles expected 1");
        end
      end else if (rsp_err) begin
        errors++;
        $display("FAIL rsp_err_qual: got err=1 expected 0 while valid=0");
      end
      prev_valid = rsp_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push_acc(input logic rw, input logic [7:0] adr, input logic [7:0] dat, input int n);
    acc_t e;
    e.rw = rw; e.adr = adr; e.dat = dat;
    for (int i = 0; i < n; i++) acc_q.push_back(e);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_data, input logic exp_err, input bit push);
    int   n;
    rsp_t e;
    if (push) begin
      e.data = exp_data; e.err = exp_err;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      errors++;
      $display("FAIL cmd_accept: got ready=0 expected 1 within 200 cycles");
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_wait: got no response expected one within %0d cycles", limit);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int a0;
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, sb_stb, sb_rw, sb_adr, sb_dat_o, rsp_data}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release", cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_clock", cmd_ready, 1'b1);

    // Reg write, ack after 1 cycle
    ack_en = 1'b1; ack_dly = 1;
    push_acc(1'b1, 8'h09, 8'hA5, 1);
    run_cmd(2'b01, 4'h9, 8'hA5, 8'h00, 1'b0, 1'b1);
    wait_rsp(100);
    chk("wr_latency", rsp_cyc - acc_cyc, 2);
    chk("wr_strobe_width", last_width, 2);

    // Reg read of RXDR, ack after 3 cycles
    ack_dly = 3; rx_val = 8'h3C;
    push_acc(1'b0, 8'h0E, 8'h00, 1);
    run_cmd(2'b00, 4'hE, 8'h00, 8'h3C, 1'b0, 1'b1);
    wait_rsp(100);
    chk("rd_strobe_width", last_width, 4);

    // Byte exchange with TRDY after 3 polls, RRDY after 2
    ack_dly = 1; rx_val = 8'hC3;
    sr_q = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h08};
    push_acc(1'b0, 8'h0C, 8'h00, 3);
    push_acc(1'b1, 8'h0D, 8'h5A, 1);
    push_acc(1'b0, 8'h0C, 8'h00, 2);
    push_acc(1'b0, 8'h0E, 8'h00, 1);
    run_cmd(2'b10, 4'h0, 8'h5A, 8'hC3, 1'b0, 1'b1);
    wait_rsp(200);
    chk("xchg_all_accesses", acc_q.size(), 0);
    chk("xchg_sr_consumed", sr_q.size(), 0);

    // Ack timeout on a reg read, then a normal command
    ack_en = 1'b0;
    push_acc(1'b0, 8'h03, 8'h00, 1);
    run_cmd(2'b00, 4'h3, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_rsp(100);
    chk("timeout_strobe_width", last_width, 16);
    ack_en = 1'b1;
    push_acc(1'b1, 8'h05, 8'h3C, 1);
    run_cmd(2'b01, 4'h5, 8'h3C, 8'h00, 1'b0, 1'b1);
    wait_rsp(100);

    // TRDY never set: poll limit
    sr_q.delete();
    a0 = acc_total;
    push_acc(1'b0, 8'h0C, 8'h00, 256);
    run_cmd(2'b10, 4'h0, 8'h99, 8'h00, 1'b1, 1'b1);
    wait_rsp(3000);
    chk("poll_limit_reads", acc_total - a0, 256);
    chk("poll_limit_queue", acc_q.size(), 0);

    // Reset mid-strobe
    ack_en = 1'b0;
    push_acc(1'b0, 8'h0E, 8'h00, 1);
    run_cmd(2'b00, 4'hE, 8'h00, 8'h00, 1'b0, 1'b0);
    n = 0;
    while (!sb_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_before_reset", sb_stb, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {cmd_ready, rsp_valid, sb_stb, sb_rw, sb_adr, sb_dat_o}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_at_release2", cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_clock2", cmd_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_rsp_after_reset", exp_q.size(), 0);

    // Reserved op: error, no bus access
    ack_en = 1'b1;
    a0 = acc_total;
    run_cmd(2'b11, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_rsp(50);
    chk("rsvd_no_access", acc_total - a0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected end before 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sb_spi_host_sequencer.md
Name: sb_spi_host_sequencer

Overview:
- Fabric-side system-bus initiator for the iCE40 hard SPI IP. It drives the IP's SBCLK-domain strobe/read-write/address/data inputs and consumes its data-out and ack outputs.
- Offers a command port with three operations: raw register read, raw register write, and full-duplex byte exchange (poll TRDY, write TXDR, poll RRDY, read RXDR).
- Sits between higher-level control logic (e.g. flash/sensor loaders) and the hard SPI macro.

Parameters:
- BUS_ADDR74, 4'b0000, upper address nibble of the targeted SPI macro instance; must match the macro's own setting.
- ACK_TIMEOUT, 16, maximum cycles a strobe is held waiting for ack before aborting.
- POLL_LIMIT, 256, maximum status reads per poll phase before aborting.

Ports:
- clk_i  in  1  system clock; also drives the macro's SBCLKI.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_op_i  in  2  00 reg read, 01 reg write, 10 byte exchange, 11 reserved.
- cmd_addr_i  in  4  register offset (ignored for exchange).
- cmd_wdata_i  in  8  write data / TX byte.
- rsp_valid_o  out  1  one-cycle completion pulse; no backpressure.
- rsp_data_o  out  8  read data / RX byte; 0 for writes.
- rsp_err_o  out  1  timeout, poll-limit or reserved-op error; qualified by rsp_valid_o.
- sb_stb_o  out  1  to SBSTBI.
- sb_rw_o  out  1  to SBRWI; 1 = write.
- sb_adr_o  out  8  to SBADRI7..0.
- sb_dat_o  out  8  to SBDATI7..0.
- sb_dat_i  in  8  from SBDATO7..0.
- sb_ack_i  in  1  from SBACKO.

Behaviour:
- Reset (async, rst_ni low): all outputs 0 immediately, cmd_ready_o 0, FSM to IDLE, counters cleared. An in-flight strobe drops immediately and no response is issued. cmd_ready_o rises on the first clock after release.
- cmd_ready_o = 1 only in IDLE. Command fields are registered on acceptance.
- Bus access (sub-module):
  - sb_stb_o rises on the cycle after start.
  - sb_adr_o = {BUS_ADDR74, offset}; sb_rw_o and sb_dat_o are held stable for the whole strobe.
  - On the first cycle sb_ack_i is sampled high, sb_dat_i is captured and sb_stb_o falls on the next edge.
  - sb_stb_o is low for at least 1 cycle between accesses.
  - If no ack arrives within ACK_TIMEOUT cycles of strobe rise, the strobe drops and the access reports a timeout.
  - An ack received while the strobe is low is ignored.
- Register offsets: SR = 4'hC, TXDR = 4'hD, RXDR = 4'hE. SR bit4 = TRDY, SR bit3 = RRDY.
- FSM states: IDLE, REG_ACC, POLL_TX, WR_TX, POLL_RX, RD_RX, RESP.
  - IDLE -> REG_ACC for op 00/01.
  - IDLE -> POLL_TX for op 10.
  - IDLE -> RESP with err=1 for op 11.
  - REG_ACC -> RESP.
  - POLL_TX: read SR repeatedly; TRDY=1 -> WR_TX. After POLL_LIMIT reads without TRDY -> RESP err.
  - WR_TX: write cmd_wdata to TXDR -> POLL_RX.
  - POLL_RX: like POLL_TX using RRDY -> RD_RX.
  - RD_RX: read RXDR, capture byte -> RESP.
  - RESP: rsp_valid_o = 1 for exactly one cycle -> IDLE.
  - A timeout in any state -> RESP with err=1 and rsp_data_o = 0.
- Poll counter is 9 bits and clears on entry to each poll state.
- Latency with ack after 1 cycle:
  - reg access: accept at T, strobe T+1, ack T+2, strobe low T+3, rsp_valid at T+3.
  - exchange with immediate TRDY/RRDY: 4 accesses, at most 3 cycles each plus gaps.
- rsp_data_o holds its value until the next response. rsp_err_o is 0 whenever rsp_valid_o is 0.

Decomposition:
- Package sb_spi_pkg:
  - op enum (OP_RD, OP_WR, OP_XCHG, OP_RSVD).
  - register offset constants SR/TXDR/RXDR and the TRDY/RRDY bit indices.
  - FSM state enum.
- Sub-module sb_bus_access: a single strobe/ack transaction with timeout. Interface: start, rw, addr, wdata; outputs done, rdata, timeout.

Test Plan:
- Reg write op01 addr 4'h9 data 8'hA5, ack 1 cycle after strobe -> sb_adr_o 8'h09, sb_rw_o 1, sb_dat_o A5 stable through strobe; rsp_valid 1 cycle, err 0, data 00.
- Reg read op00 addr 4'hE, model returns 8'h3C with ack after 3 cycles -> rsp_data 3C, err 0; strobe width exactly 4 cycles.
- Exchange wdata 8'h5A: SR returns TRDY=0 twice then 1, later RRDY=0 once then 1, RXDR = 8'hC3 -> access sequence SR,SR,SR,TXDR(wr 5A),SR,SR,RXDR; rsp_data C3, err 0; at least 1 low cycle between strobes.
- Ack never asserted on a reg read -> strobe drops after 16 cycles; rsp_err 1, data 00; next command accepted.
- TRDY never set -> exactly 256 SR reads then rsp_err 1; no TXDR write occurs.
- rst_ni asserted mid-strobe -> sb_stb_o 0 asynchronously, no rsp_valid; op 11 after reset -> rsp_err 1 with no bus access.
